// File: rtl/stoch_sng_dru_if.sv
// Bundles the data signals of the stochastic encode/decode pair.
//   A       : unsigned value to encode (driven by the master)
//   Y       : stochastic bitstream (driven by the slave)
//   a       : recovered value, updated once per LFSR period (slave)
//   a_valid : one-cycle pulse when a is updated (slave)
interface stoch_sng_dru_if #(
  parameter int unsigned n = 4
);
  logic [n-1:0] A;
  logic         Y;
  logic [n-1:0] a;
  logic         a_valid;

  modport master (
    output A,
    input  Y,
    input  a,
    input  a_valid
  );

  modport slave (
    input  A,
    output Y,
    output a,
    output a_valid
  );
endinterface

// File: rtl/stoch_sng_dru.sv
// Stochastic number generator plus de-randomizer.
// The SNG compares A against a maximal-length Fibonacci LFSR, giving a serial
// bitstream Y with exactly A ones per LFSR period. The DRU counts the ones in
// Y over one full period and presents the count on a, with a one-cycle
// a_valid pulse.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : stoch_sng_dru_if slave (A in; Y, a, a_valid out)
module stoch_sng_dru #(
  parameter int unsigned n = 4
) (
  input  logic            clk,
  input  logic            rst,
  stoch_sng_dru_if.slave  bus
);

  // Feedback taps as a bit mask (bit t-1 set for 1-based tap t).
  function automatic logic [15:0] tap_mask(input int unsigned w);
    case (w)
      3:       tap_mask = 16'h0006;
      4:       tap_mask = 16'h000C;
      5:       tap_mask = 16'h0014;
      6:       tap_mask = 16'h0030;
      7:       tap_mask = 16'h0060;
      8:       tap_mask = 16'h00B8;
      9:       tap_mask = 16'h0110;
      10:      tap_mask = 16'h0240;
      11:      tap_mask = 16'h0500;
      12:      tap_mask = 16'h0829;
      13:      tap_mask = 16'h100D;
      14:      tap_mask = 16'h2015;
      15:      tap_mask = 16'h6000;
      16:      tap_mask = 16'hD008;
      default: tap_mask = 16'h0000;
    endcase
  endfunction

  localparam logic [15:0]  TapMaskFull = tap_mask(n);
  localparam logic [n-1:0] TapMask     = TapMaskFull[n-1:0];
  // Last window count is P-1 = 2^n - 2.
  localparam logic [n-1:0] WcntLast    = {{(n-1){1'b1}}, 1'b0};
  localparam logic [n-1:0] LfsrSeed    = {{(n-1){1'b0}}, 1'b1};

  logic [n-1:0] lfsr_q, lfsr_d;
  logic [n-1:0] wcnt_q, wcnt_d;
  logic [n-1:0] ones_q, ones_d;
  logic [n-1:0] a_q, a_d;
  logic         a_valid_q, a_valid_d;
  logic         y;
  logic         fb;
  logic [n-1:0] y_ext;

  assign y     = (bus.A >= lfsr_q);
  assign y_ext = {{(n-1){1'b0}}, y};
  assign fb    = ^(lfsr_q & TapMask);

  always_comb begin
    lfsr_d    = {lfsr_q[n-2:0], fb};
    wcnt_d    = wcnt_q + 1'b1;
    ones_d    = ones_q + y_ext;
    a_d       = a_q;
    a_valid_d = 1'b0;
    if (wcnt_q == WcntLast) begin
      // ones_q <= P-1 here, so ones_q + y never exceeds P = 2^n - 1.
      a_d       = ones_q + y_ext;
      a_valid_d = 1'b1;
      ones_d    = '0;
      wcnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q    <= LfsrSeed;
      wcnt_q    <= '0;
      ones_q    <= '0;
      a_q       <= '0;
      a_valid_q <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_d;
      wcnt_q    <= wcnt_d;
      ones_q    <= ones_d;
      a_q       <= a_d;
      a_valid_q <= a_valid_d;
    end
  end

  assign bus.Y       = y;
  assign bus.a       = a_q;
  assign bus.a_valid = a_valid_q;

endmodule

// File: tb/tb_stoch_sng_dru.sv
module tb_stoch_sng_dru;

  logic clk;
  logic rst;
  logic rst_sw;

  int n_tests = 0;
  int n_fail  = 0;

  stoch_sng_dru_if #(.n(4))  bus4 ();
  stoch_sng_dru_if #(.n(3))  bus3 ();
  stoch_sng_dru_if #(.n(8))  bus8 ();
  stoch_sng_dru_if #(.n(16)) bus16 ();

  stoch_sng_dru #(.n(4))  dut4  (.clk(clk), .rst(rst),    .bus(bus4));
  stoch_sng_dru #(.n(3))  dut3  (.clk(clk), .rst(rst_sw), .bus(bus3));
  stoch_sng_dru #(.n(8))  dut8  (.clk(clk), .rst(rst_sw), .bus(bus8));
  stoch_sng_dru #(.n(16)) dut16 (.clk(clk), .rst(rst_sw), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed n=4 LFSR sequence (taps 4,3, seed 1) and Y for A=5.
  typedef struct {
    logic [3:0] lfsr;
    logic       y5;
  } vec_t;
  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full window from wcnt=0: A=a0 before edge index sw, a1 from then on.
  task automatic run_window(input logic [3:0] a0, input logic [3:0] a1, input int sw,
                            input logic [3:0] a_exp, input logic [3:0] a_hold);
    logic [3:0] av;
    for (int i = 0; i < 15; i++) begin
      av = (i < sw) ? a0 : a1;
      bus4.A = av;
      #1;
      check("lfsr_seq", 32'(dut4.lfsr_q), 32'(tbl[i].lfsr));
      check("y_cmp", 32'(bus4.Y), 32'(av >= tbl[i].lfsr));
      step();
      if (i < 14) begin
        check("a_valid_low", 32'(bus4.a_valid), 32'd0);
        check("a_hold", 32'(bus4.a), 32'(a_hold));
      end else begin
        check("a_valid_pulse", 32'(bus4.a_valid), 32'd1);
        check("a_value", 32'(bus4.a), 32'(a_exp));
      end
    end
  endtask

  initial begin
    int ones_seen;
    int seen_mask;

    tbl[0]  = '{4'd1,  1'b1};
    tbl[1]  = '{4'd2,  1'b1};
    tbl[2]  = '{4'd4,  1'b1};
    tbl[3]  = '{4'd9,  1'b0};
    tbl[4]  = '{4'd3,  1'b1};
    tbl[5]  = '{4'd6,  1'b0};
    tbl[6]  = '{4'd13, 1'b0};
    tbl[7]  = '{4'd10, 1'b0};
    tbl[8]  = '{4'd5,  1'b1};
    tbl[9]  = '{4'd11, 1'b0};
    tbl[10] = '{4'd7,  1'b0};
    tbl[11] = '{4'd15, 1'b0};
    tbl[12] = '{4'd14, 1'b0};
    tbl[13] = '{4'd12, 1'b0};
    tbl[14] = '{4'd8,  1'b0};

    rst      = 1'b0;
    rst_sw   = 1'b0;
    bus4.A   = 4'd5;
    bus3.A   = 3'd6;
    bus8.A   = 8'd254;
    bus16.A  = 16'd65534;

    // Reset state.
    step();
    step();
    check("rst_lfsr", 32'(dut4.lfsr_q), 32'd1);
    check("rst_a", 32'(bus4.a), 32'd0);
    check("rst_a_valid", 32'(bus4.a_valid), 32'd0);
    check("rst_y", 32'(bus4.Y), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // First window, A=5: table-driven LFSR/Y check and full-period coverage.
    ones_seen = 0;
    seen_mask = 0;
    for (int i = 0; i < 15; i++) begin
      #1;
      check("tbl_lfsr", 32'(dut4.lfsr_q), 32'(tbl[i].lfsr));
      check("tbl_y", 32'(bus4.Y), 32'(tbl[i].y5));
      if (bus4.Y) ones_seen++;
      seen_mask = seen_mask | (1 << dut4.lfsr_q);
      step();
      if (i < 14) check("tbl_a_valid_low", 32'(bus4.a_valid), 32'd0);
    end
    check("ones_in_window", 32'(ones_seen), 32'd5);
    check("lfsr_all_values", 32'(seen_mask), 32'hFFFE);
    check("lfsr_period", 32'(dut4.lfsr_q), 32'd1);
    check("first_a", 32'(bus4.a), 32'd5);
    check("first_a_valid", 32'(bus4.a_valid), 32'd1);

    // Repeat, then extremes, then boundary change to 12.
    run_window(4'd5,  4'd5,  15, 4'd5,  4'd5);
    run_window(4'd0,  4'd0,  15, 4'd0,  4'd5);
    run_window(4'd15, 4'd15, 15, 4'd15, 4'd0);
    run_window(4'd12, 4'd12, 15, 4'd12, 4'd15);
    // Mid-window change: 4 ones from A=5 on states 0..6, 6 from A=12 on 7..14.
    run_window(4'd5,  4'd12, 7,  4'd10, 4'd12);
    run_window(4'd12, 4'd12, 15, 4'd12, 4'd10);

    // Asynchronous reset at cycle 7, between edges.
    bus4.A = 4'd5;
    for (int i = 0; i < 7; i++) step();
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_a", 32'(bus4.a), 32'd0);
    check("mid_rst_a_valid", 32'(bus4.a_valid), 32'd0);
    check("mid_rst_ones", 32'(dut4.ones_q), 32'd0);
    check("mid_rst_wcnt", 32'(dut4.wcnt_q), 32'd0);
    check("mid_rst_lfsr", 32'(dut4.lfsr_q), 32'd1);
    step();
    check("rst_hold_lfsr", 32'(dut4.lfsr_q), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    run_window(4'd5, 4'd5, 15, 4'd5, 4'd0);

    // Reset while the a_valid pulse is high clears it immediately.
    #1;
    rst = 1'b0;
    #1;
    check("pulse_rst_a_valid", 32'(bus4.a_valid), 32'd0);
    check("pulse_rst_a", 32'(bus4.a), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Width sweep: A = 2^n-2 recovered after 2^n-1 edges.
    @(negedge clk);
    rst_sw = 1'b1;
    for (int k = 1; k <= 65535; k++) begin
      step();
      if (k == 6) check("n3_a_valid_low", 32'(bus3.a_valid), 32'd0);
      if (k == 7) begin
        check("n3_a_valid", 32'(bus3.a_valid), 32'd1);
        check("n3_a", 32'(bus3.a), 32'd6);
      end
      if (k == 254) check("n8_a_valid_low", 32'(bus8.a_valid), 32'd0);
      if (k == 255) begin
        check("n8_a_valid", 32'(bus8.a_valid), 32'd1);
        check("n8_a", 32'(bus8.a), 32'd254);
      end
      if (k == 65534) begin
        check("n16_a_valid_low", 32'(bus16.a_valid), 32'd0);
        check("n16_a_before", 32'(bus16.a), 32'd0);
      end
      if (k == 65535) begin
        check("n16_a_valid", 32'(bus16.a_valid), 32'd1);
        check("n16_a", 32'(bus16.a), 32'd65534);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
